// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/
// writeback over a shared ALU and single memory, one state per cycle.
// Ports:
//   clk_i, rst_i (async, active-high)
//   Op_i          instruction opcode (IR[31:26]), sampled in DECODE/MEM_ADDR
//   mem_ready_i   memory completes current access this cycle
//   PCWrite_o .. RegDst_o  datapath selects and write enables (from state)
//   state_o       current FSM state
//   illegal_o     sticky undecodable-opcode flag
//   instr_count_o retired-instruction counter (wraps)
module multicycle_control #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         Op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic               MemtoReg_o,
    output logic [1:0]         PCSource_o,
    output logic [1:0]         ALUOp_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_WB_LOAD   = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_WB_R      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_WB_I      = 4'd11,
        S_ILLEGAL   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               illegal_q, illegal_d;
    logic               retire_c;

    // unmasked enables, gated by reset before leaving the block
    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

    // State, counter and sticky flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and retirement decode
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH:     if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (Op_i)
                    OP_RTYPE:    state_d = S_EXEC_R;
                    OP_ADDI:     state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:      state_d = S_BRANCH;
                    OP_J:        state_d = S_JUMP;
                    default:     state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_d = (Op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready_i) state_d = S_WB_LOAD;
            S_MEM_WRITE: begin
                if (mem_ready_i) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_EXEC_I:    state_d = S_WB_I;
            S_WB_LOAD, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_FETCH;  // unused encodings recover
        endcase
        count_d   = retire_c ? count_q + COUNT_W'(1) : count_q;
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    // Datapath controls decoded from the current state
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        IorD_o        = 1'b0;
        MemtoReg_o    = 1'b0;
        PCSource_o    = 2'b00;
        ALUOp_o       = 2'b00;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        RegDst_o      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ALUSrcB_o = 2'b01;
                ir_write  = mem_ready_i;
                pc_write  = mem_ready_i;
            end
            S_DECODE:    ALUSrcB_o = 2'b11;
            S_MEM_ADDR, S_EXEC_I: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                IorD_o   = 1'b1;
            end
            S_WB_LOAD: begin
                reg_write  = 1'b1;
                MemtoReg_o = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                IorD_o    = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                RegDst_o  = 1'b1;
            end
            S_WB_I:      reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = 2'b01;
                pc_write_cond = 1'b1;
                PCSource_o    = 2'b01;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                PCSource_o = 2'b10;
            end
            default: ;
        endcase
        // reset abandons any access in the same cycle it rises
        PCWrite_o     = pc_write      & ~rst_i;
        PCWriteCond_o = pc_write_cond & ~rst_i;
        MemRead_o     = mem_read      & ~rst_i;
        MemWrite_o    = mem_write     & ~rst_i;
        IRWrite_o     = ir_write      & ~rst_i;
        RegWrite_o    = reg_write     & ~rst_i;
    end

    assign state_o       = state_q;
    assign illegal_o     = illegal_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (COUNT_W=4 to reach the wrap).
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    //  PCSource[2],ALUOp[2],ALUSrcA,ALUSrcB[2],RegWrite,RegDst}
    localparam logic [15:0] C_ZERO       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_RESET      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0};
    localparam logic [15:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0};
    localparam logic [15:0] C_FETCH_GO   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0};
    localparam logic [15:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0};
    localparam logic [15:0] C_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0};
    localparam logic [15:0] C_MEM_READ   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_WB_LOAD    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
    localparam logic [15:0] C_MEM_WRITE  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_EXEC_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_WB_R       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b1};
    localparam logic [15:0] C_EXEC_I     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0};
    localparam logic [15:0] C_WB_I       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
    localparam logic [15:0] C_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b1,2'b00,1'b0,1'b0};
    localparam logic [15:0] C_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0};

    typedef struct packed {
        logic [15:0]   tag;
        logic [3:0]    st;
        logic [15:0]   ctl;
        logic [CW-1:0] cnt;
        logic          ill;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [5:0]    Op_i;
    logic          mem_ready_i;
    logic          PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
    logic          IRWrite_o, MemtoReg_o, ALUSrcA_o, RegWrite_o, RegDst_o;
    logic [1:0]    PCSource_o, ALUOp_o, ALUSrcB_o;
    logic [3:0]    state_o;
    logic          illegal_o;
    logic [CW-1:0] instr_count_o;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          waited   = 0;
    logic [15:0] tag_n    = 16'd0;
    logic [15:0] ctl_got;

    multicycle_control #(.COUNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .Op_i          (Op_i),
        .mem_ready_i   (mem_ready_i),
        .PCWrite_o     (PCWrite_o),
        .PCWriteCond_o (PCWriteCond_o),
        .IorD_o        (IorD_o),
        .MemRead_o     (MemRead_o),
        .MemWrite_o    (MemWrite_o),
        .IRWrite_o     (IRWrite_o),
        .MemtoReg_o    (MemtoReg_o),
        .PCSource_o    (PCSource_o),
        .ALUOp_o       (ALUOp_o),
        .ALUSrcA_o     (ALUSrcA_o),
        .ALUSrcB_o     (ALUSrcB_o),
        .RegWrite_o    (RegWrite_o),
        .RegDst_o      (RegDst_o),
        .state_o       (state_o),
        .illegal_o     (illegal_o),
        .instr_count_o (instr_count_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctl_got = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                      IRWrite_o, MemtoReg_o, PCSource_o, ALUOp_o, ALUSrcA_o,
                      ALUSrcB_o, RegWrite_o, RegDst_o};

    // One cycle: drive inputs just after the edge and queue what the DUT
    // must show for the remainder of this cycle.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [15:0] ctl,
                        input logic [CW-1:0] cnt, input logic ill);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i       = r;
        Op_i        = op;
        mem_ready_i = rdy;
        e.tag = tag_n;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = cnt;
        e.ill = ill;
        exp_q.push_back(e);
        tag_n = tag_n + 16'd1;
    endtask

    // Monitor: every cycle presents an output; compare on the falling edge.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (state_o !== e.st || ctl_got !== e.ctl ||
                instr_count_o !== e.cnt || illegal_o !== e.ill) begin
                failures = failures + 1;
                $display("FAIL vec%0d: got state=%0d ctl=%h cnt=%0d ill=%b, want state=%0d ctl=%h cnt=%0d ill=%b",
                         e.tag, state_o, ctl_got, instr_count_o, illegal_o,
                         e.st, e.ctl, e.cnt, e.ill);
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #100000;
        failures = failures + 1;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_i       = 1'b1;
        Op_i        = OP_R;
        mem_ready_i = 1'b1;

        // reset state visible before any clock edge
        #1;
        checks = checks + 1;
        if (state_o !== 4'd0 || instr_count_o !== 4'd0 || illegal_o !== 1'b0 ||
            PCWrite_o !== 1'b0 || PCWriteCond_o !== 1'b0 || MemRead_o !== 1'b0 ||
            MemWrite_o !== 1'b0 || IRWrite_o !== 1'b0 || RegWrite_o !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset: state=%0d cnt=%0d ill=%b ctl=%h",
                     state_o, instr_count_o, illegal_o, ctl_got);
        end

        // reset: enables masked, selects still show FETCH
        step(1'b1, OP_R, 1'b1, 4'd0, C_RESET, 4'd0, 1'b0);
        step(1'b1, OP_R, 1'b1, 4'd0, C_RESET, 4'd0, 1'b0);

        // R-type: 0,1,6,7
        step(1'b0, OP_R, 1'b1, 4'd0, C_FETCH_GO, 4'd0, 1'b0);
        step(1'b0, OP_R, 1'b1, 4'd1, C_DECODE,   4'd0, 1'b0);
        step(1'b0, OP_R, 1'b1, 4'd6, C_EXEC_R,   4'd0, 1'b0);
        step(1'b0, OP_R, 1'b1, 4'd7, C_WB_R,     4'd0, 1'b0);

        // fetch stalled 3 cycles, then addi; Op change in EXEC_I ignored
        step(1'b0, OP_ADDI, 1'b0, 4'd0,  C_FETCH_WAIT, 4'd1, 1'b0);
        step(1'b0, OP_ADDI, 1'b0, 4'd0,  C_FETCH_WAIT, 4'd1, 1'b0);
        step(1'b0, OP_ADDI, 1'b0, 4'd0,  C_FETCH_WAIT, 4'd1, 1'b0);
        step(1'b0, OP_ADDI, 1'b1, 4'd0,  C_FETCH_GO,   4'd1, 1'b0);
        step(1'b0, OP_ADDI, 1'b1, 4'd1,  C_DECODE,     4'd1, 1'b0);
        step(1'b0, OP_R,    1'b1, 4'd10, C_EXEC_I,     4'd1, 1'b0);
        step(1'b0, OP_R,    1'b1, 4'd11, C_WB_I,       4'd1, 1'b0);

        // lw with two wait cycles in MEM_READ: 7 cycles
        step(1'b0, OP_LW, 1'b1, 4'd0, C_FETCH_GO, 4'd2, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd1, C_DECODE,   4'd2, 1'b0);
        step(1'b0, OP_LW, 1'b0, 4'd2, C_MEM_ADDR, 4'd2, 1'b0);
        step(1'b0, OP_LW, 1'b0, 4'd3, C_MEM_READ, 4'd2, 1'b0);
        step(1'b0, OP_LW, 1'b0, 4'd3, C_MEM_READ, 4'd2, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd3, C_MEM_READ, 4'd2, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd4, C_WB_LOAD,  4'd2, 1'b0);

        // sw: Op says lw in DECODE but sw in MEM_ADDR, so MEM_WRITE is taken
        step(1'b0, OP_LW, 1'b1, 4'd0, C_FETCH_GO,  4'd3, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd1, C_DECODE,    4'd3, 1'b0);
        step(1'b0, OP_SW, 1'b0, 4'd2, C_MEM_ADDR,  4'd3, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd5, C_MEM_WRITE, 4'd3, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd0, C_FETCH_GO,  4'd4, 1'b0);

        // beq (garbage Op in BRANCH ignored)
        step(1'b0, OP_BEQ, 1'b1, 4'd1, C_DECODE,   4'd4, 1'b0);
        step(1'b0, OP_BAD, 1'b1, 4'd8, C_BRANCH,   4'd4, 1'b0);

        // j
        step(1'b0, OP_J,   1'b1, 4'd0, C_FETCH_GO, 4'd5, 1'b0);
        step(1'b0, OP_J,   1'b1, 4'd1, C_DECODE,   4'd5, 1'b0);
        step(1'b0, OP_BAD, 1'b1, 4'd9, C_JUMP,     4'd5, 1'b0);

        // illegal opcode: stuck in ILLEGAL, enables 0, count frozen
        step(1'b0, OP_BAD, 1'b1, 4'd0, C_FETCH_GO, 4'd6, 1'b0);
        step(1'b0, OP_BAD, 1'b1, 4'd1, C_DECODE,   4'd6, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, OP_J, 1'b1, 4'd15, C_ZERO, 4'd6, 1'b1);
        // reset raised mid-cycle: visible before any clock edge
        step(1'b1, OP_J, 1'b1, 4'd0, C_RESET, 4'd0, 1'b0);

        // reset during a pending lw read drops MemRead at once
        step(1'b0, OP_LW, 1'b1, 4'd0, C_FETCH_GO, 4'd0, 1'b0);
        step(1'b0, OP_LW, 1'b1, 4'd1, C_DECODE,   4'd0, 1'b0);
        step(1'b0, OP_LW, 1'b0, 4'd2, C_MEM_ADDR, 4'd0, 1'b0);
        step(1'b0, OP_LW, 1'b0, 4'd3, C_MEM_READ, 4'd0, 1'b0);
        step(1'b1, OP_LW, 1'b0, 4'd0, C_RESET,    4'd0, 1'b0);

        // 16 back-to-back jumps: counter walks 0..15 and wraps to 0
        for (int i = 0; i < 16; i++) begin
            step(1'b0, OP_J, 1'b1, 4'd0, C_FETCH_GO, CW'(i), 1'b0);
            step(1'b0, OP_J, 1'b1, 4'd1, C_DECODE,   CW'(i), 1'b0);
            step(1'b0, OP_J, 1'b1, 4'd9, C_JUMP,     CW'(i), 1'b0);
        end
        step(1'b0, OP_J, 1'b1, 4'd0, C_FETCH_GO, 4'd0, 1'b0);

        // bounded wait for the scoreboard to drain
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk_i);
            waited = waited + 1;
        end
        checks = checks + 1;
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL wait expired: %0d expectations still pending", exp_q.size());
        end
        @(negedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name:
multicycle_control

Overview:
Multi-cycle MIPS main controller. It sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback steps, one FSM state per cycle. It emits all datapath mux selects and write enables and stalls on the memory ready handshake. It supports R-type, addi, lw, sw, beq and j.

Parameters:
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  asynchronous, active-high reset
Op_i  input  6  opcode field of the instruction register (IR[31:26])
mem_ready_i  input  1  memory completes the current read/write this cycle
PCWrite_o  output  1  unconditional PC write
PCWriteCond_o  output  1  PC write if ALU zero
IorD_o  output  1  memory address select: 0=PC, 1=ALUOut
MemRead_o  output  1  memory read request
MemWrite_o  output  1  memory write request
IRWrite_o  output  1  instruction register load
MemtoReg_o  output  1  register write data: 0=ALUOut, 1=MDR
PCSource_o  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
ALUOp_o  output  2  00=add, 01=sub, 10=funct decode
ALUSrcA_o  output  1  0=PC, 1=reg A
ALUSrcB_o  output  2  00=reg B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
RegWrite_o  output  1  register file write enable
RegDst_o  output  1  destination register: 0=rt, 1=rd
state_o  output  4  current FSM state (debug)
illegal_o  output  1  sticky flag: undecodable opcode
instr_count_o  output  COUNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous, rst_i=1): state=FETCH(0), instr_count_o=0, illegal_o=0. While rst_i=1, every write and request enable is forced to 0. These are PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite and RegWrite.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, WB_LOAD=4, MEM_WRITE=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, EXEC_I=10, WB_I=11, ILLEGAL=15. Encodings 12-14 go to FETCH on the next edge.
- Outputs are combinational from the state, plus mem_ready_i where stated. Any output not listed for a state is driven to 0, never x.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - When mem_ready_i=1: IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE.
  - When mem_ready_i=0: IRWrite=0, PCWrite=0, and the state holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target computed into ALUOut). Next state by Op_i:
  - 000000 -> EXEC_R
  - 001000 -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ if Op_i=100011, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready_i=1, then go to WB_LOAD.
- WB_LOAD: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, held while waiting. On mem_ready_i=1, go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ILLEGAL: all enables 0, illegal_o=1. Only reset exits this state.
- Latency with mem_ready_i held at 1: R-type 4 cycles, addi 4, lw 5, sw 4, beq 3, j 3. Each cycle of mem_ready_i=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Retirement: instr_count_o increments by 1 on the edge that leaves a terminal state for FETCH. Terminal states are WB_LOAD, MEM_WRITE (on ready), WB_R, WB_I, BRANCH and JUMP.
  - The counter wraps from 2^COUNT_W-1 to 0.
  - It never counts ILLEGAL.
- Reset during a pending memory access abandons the access. MemRead and MemWrite drop in the same cycle that rst_i rises.
- Op_i is sampled only in DECODE and MEM_ADDR. Changes to Op_i in other states have no effect.

Test Plan:
- Reset, mem_ready_i=1, Op_i=000000 -> state_o 0,1,6,7,0. RegWrite_o=1 with RegDst_o=1 only in cycle 4. instr_count_o=1 afterwards.
- FETCH with mem_ready_i=0 for 3 cycles, then 1 -> IRWrite_o and PCWrite_o stay 0 for 3 cycles and are 1 only in the 4th. MemRead_o=1 in all 4 cycles.
- lw (100011) with mem_ready_i=0 for 2 cycles in MEM_READ -> state_o=3 for 3 cycles with MemRead_o=1 and IorD_o=1. Then WB_LOAD with MemtoReg_o=1 and RegWrite_o=1. 7 cycles in total.
- beq (000100) -> states 0,1,8; in cycle 3 PCWriteCond_o=1, ALUOp_o=01, PCSource_o=01. j (000010) -> cycle 3 has PCWrite_o=1, PCSource_o=10.
- Op_i=111111 -> state_o=15 and illegal_o=1 after DECODE. All enables stay 0 for 10 cycles and the count is unchanged. Asserting rst_i mid-cycle gives state_o=0 and illegal_o=0 immediately, with no clock edge.
- COUNT_W=4, 16 back-to-back j instructions -> instr_count_o goes 15 -> 0 on the 16th retirement.
